multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/multi_debouncer.sv | 123 ++++++++++++
 tb/tb_multi_debouncer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer with press/release pulses and long-press detect.
// Define DEBOUNCE_REPEAT_EN to enable auto-repeat pulses on pb_rep while a long press is held.

module multi_debouncer_ch #(
    parameter int CNT_W      = 16,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int LONG_CYC   = 1000000,
    parameter int REP_CYC    = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    output logic pb_state,
    output logic pb_down,
    output logic pb_up,
    output logic pb_long,
    output logic pb_rep
);
    // Hold and repeat counters share one width, sized for the larger limit.
    localparam int HW = $clog2(((LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC) + 1);
    localparam logic [HW-1:0] LONG_V = HW'(LONG_CYC);

    logic [1:0]      sync;
    logic [CNT_W-1:0] cnt;
    logic [HW-1:0]   hold;
    logic            s, idle, toggle, state_nxt;
    logic [HW-1:0]   hold_nxt;

    assign s         = sync[1];
    assign idle      = (s == pb_state);
    assign toggle    = !idle && (&cnt);
    assign state_nxt = pb_state ^ toggle;
    assign pb_long   = (hold == LONG_V);

    always_comb begin
        hold_nxt = hold;
        if (!state_nxt)
            hold_nxt = '0;
        else if (hold != LONG_V)
            hold_nxt = hold + 1'b1;
    end

    // Polarity is folded in ahead of the synchroniser so reset leaves it at not-pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            cnt      <= '0;
            pb_state <= 1'b0;
            pb_down  <= 1'b0;
            pb_up    <= 1'b0;
            hold     <= '0;
        end else begin
            sync     <= {sync[0], ACTIVE_LOW ? ~pb : pb};
            cnt      <= (idle || (&cnt)) ? '0 : cnt + 1'b1;
            pb_state <= state_nxt;
            pb_down  <= toggle & ~pb_state;
            pb_up    <= toggle & pb_state;
            hold     <= hold_nxt;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [HW-1:0] REP_V = HW'(REP_CYC);
    logic [HW-1:0] rep_cnt;
    logic          long_nxt;

    assign long_nxt = (hold_nxt == LONG_V);

    // First pulse lands with the long-press edge, then one every REP_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            pb_rep  <= 1'b0;
        end else if (long_nxt && !pb_long) begin
            rep_cnt <= HW'(1);
            pb_rep  <= 1'b1;
        end else if (long_nxt) begin
            pb_rep  <= (rep_cnt == REP_V);
            rep_cnt <= (rep_cnt == REP_V) ? HW'(1) : rep_cnt + 1'b1;
        end else begin
            rep_cnt <= '0;
            pb_rep  <= 1'b0;
        end
    end
`else
    assign pb_rep = 1'b0;
`endif
endmodule

module multi_debouncer #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 16,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int LONG_CYC   = 1000000,
    parameter int REP_CYC    = 250000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] pb,
    output logic [NCH-1:0] pb_state,
    output logic [NCH-1:0] pb_down,
    output logic [NCH-1:0] pb_up,
    output logic [NCH-1:0] pb_long,
    output logic [NCH-1:0] pb_rep
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        multi_debouncer_ch #(
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW),
            .LONG_CYC   (LONG_CYC),
            .REP_CYC    (REP_CYC)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .pb       (pb[i]),
            .pb_state (pb_state[i]),
            .pb_down  (pb_down[i]),
            .pb_up    (pb_up[i]),
            .pb_long  (pb_long[i]),
            .pb_rep   (pb_rep[i])
        );
    end
endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with NCH=4, CNT_W=4, LONG_CYC=40, REP_CYC=10.
module tb_multi_debouncer;
    localparam int NCH = 4;
`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [3:0] REPX = 4'b0100;
`else
    localparam logic [3:0] REPX = 4'b0000;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] pb = '1;
    logic [NCH-1:0] pb_state, pb_down, pb_up, pb_long, pb_rep;

    int checks = 0;
    int errors = 0;
    int down_cnt [NCH];
    int up_cnt   [NCH];

    multi_debouncer #(
        .NCH(NCH), .CNT_W(4), .ACTIVE_LOW(1'b1), .LONG_CYC(40), .REP_CYC(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb(pb),
        .pb_state(pb_state), .pb_down(pb_down), .pb_up(pb_up),
        .pb_long(pb_long), .pb_rep(pb_rep)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            down_cnt[i] = 0;
            up_cnt[i]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (pb_down[i]) down_cnt[i]++;
            if (pb_up[i])   up_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick(3);
        chk("rst_state", 32'(pb_state), 0);
        chk("rst_down",  32'(pb_down),  0);
        chk("rst_up",    32'(pb_up),    0);
        chk("rst_long",  32'(pb_long),  0);
        chk("rst_rep",   32'(pb_rep),   0);
        @(negedge clk) rst_n = 1'b1;
        tick(5);
        chk("idle_state", 32'(pb_state), 0);

        // press ch0: change on edge 18
        @(negedge clk) pb[0] = 1'b0;
        tick(17);
        chk("p0_e17_state", 32'(pb_state), 0);
        tick(1);
        chk("p0_e18_state", 32'(pb_state), 32'h1);
        chk("p0_e18_down",  32'(pb_down),  32'h1);
        chk("p0_e18_up",    32'(pb_up),    0);
        tick(1);
        chk("p0_e19_down",  32'(pb_down),  0);

        // ch1 glitch of 10 cycles is rejected
        @(negedge clk) pb[1] = 1'b0;
        repeat (10) @(negedge clk);
        pb[1] = 1'b1;
        tick(30);
        chk("g1_state", 32'(pb_state), 32'h1);

        // release ch0
        @(negedge clk) pb[0] = 1'b1;
        tick(17);
        chk("r0_e17_state", 32'(pb_state), 32'h1);
        chk("r0_e17_up",    32'(pb_up),    0);
        tick(1);
        chk("r0_e18_state", 32'(pb_state), 0);
        chk("r0_e18_up",    32'(pb_up),    32'h1);
        chk("r0_e18_down",  32'(pb_down),  0);
        tick(1);
        chk("r0_e19_up",    32'(pb_up),    0);
        @(negedge clk); #1;
        chk("cnt_down0", 32'(down_cnt[0]), 1);
        chk("cnt_up0",   32'(up_cnt[0]),   1);
        chk("cnt_down1", 32'(down_cnt[1]), 0);
        chk("cnt_up1",   32'(up_cnt[1]),   0);

        // long press on ch2, repeat pulses
        @(negedge clk) pb[2] = 1'b0;
        tick(18);
        chk("l2_state", 32'(pb_state), 32'h4);
        tick(38);
        chk("l2_c39_long", 32'(pb_long), 0);
        chk("l2_c39_rep",  32'(pb_rep),  0);
        tick(1);
        chk("l2_c40_long", 32'(pb_long), 32'h4);
        chk("l2_c40_rep",  32'(pb_rep),  32'(REPX));
        tick(1);
        chk("l2_c41_rep",  32'(pb_rep),  0);
        tick(9);
        chk("l2_c50_rep",  32'(pb_rep),  32'(REPX));
        tick(1);
        chk("l2_c51_rep",  32'(pb_rep),  0);
        tick(9);
        chk("l2_c60_rep",  32'(pb_rep),  32'(REPX));
        tick(40);
        chk("l2_c100_long", 32'(pb_long), 32'h4);

        // asynchronous reset mid-cycle while long is active
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(pb_state), 0);
        chk("ar_long",  32'(pb_long),  0);
        chk("ar_rep",   32'(pb_rep),   0);
        chk("ar_down",  32'(pb_down),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(17);
        chk("rr_e17_state", 32'(pb_state), 0);
        tick(1);
        chk("rr_e18_down",  32'(pb_down),  32'h4);
        chk("rr_e18_state", 32'(pb_state), 32'h4);
        tick(40);
        chk("rr_c41_long",  32'(pb_long),  32'h4);

        // release: long falls with pb_state
        @(negedge clk) pb[2] = 1'b1;
        tick(17);
        chk("lr_e17_long",  32'(pb_long),  32'h4);
        tick(1);
        chk("lr_e18_state", 32'(pb_state), 0);
        chk("lr_e18_long",  32'(pb_long),  0);
        chk("lr_e18_up",    32'(pb_up),    32'h4);

        // simultaneous press on ch2 and ch3
        tick(5);
        @(negedge clk) pb[3:2] = 2'b00;
        tick(17);
        chk("s23_e17_down",  32'(pb_down),  0);
        tick(1);
        chk("s23_e18_down",  32'(pb_down),  32'hC);
        chk("s23_e18_state", 32'(pb_state), 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
